// File: rtl/stopwatch_core.sv
// ============================================================================
// Module   : stopwatch_core
// Purpose  : Run/stop/clear stopwatch counting 100 Hz ticks as BCD SS.hh.
//            Optional lap-hold display freeze: define STOPWATCH_LAP_HOLD_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_core #(
  parameter int WRAP_TENS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       startstop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       running,
  output logic       ovf,
  output logic       lap_held
);

  localparam logic [3:0] c_WRAP = 4'(WRAP_TENS);
  localparam logic [3:0] c_NINE = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_d3, r_d2, r_d1, r_d0;
  logic       r_ovf;
  logic       w_count_en;
  logic       w_zero;
  logic       w_c0, w_c1, w_c2, w_wrap;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // clear beats startstop in STOP; clear is ignored elsewhere
  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    w_zero      = 1'b0;
    case (r_state)
      S_IDLE: if (startstop) w_state_nxt = S_RUN;
      S_RUN: begin
        w_count_en = tick;
        if (startstop) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_zero      = 1'b1;
        end else if (startstop) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_c0   = (r_d0 == c_NINE);
  assign w_c1   = w_c0 && (r_d1 == c_NINE);
  assign w_c2   = w_c1 && (r_d2 == c_NINE);
  assign w_wrap = w_c2 && (r_d3 == c_WRAP);

  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      r_d0  <= 4'd0;
      r_d1  <= 4'd0;
      r_d2  <= 4'd0;
      r_d3  <= 4'd0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_count_en && w_wrap;
      if (w_count_en) begin
        r_d0 <= w_c0 ? 4'd0 : r_d0 + 4'd1;
        if (w_c0) r_d1 <= (r_d1 == c_NINE) ? 4'd0 : r_d1 + 4'd1;
        if (w_c1) r_d2 <= (r_d2 == c_NINE) ? 4'd0 : r_d2 + 4'd1;
        if (w_c2) r_d3 <= (r_d3 == c_WRAP) ? 4'd0 : r_d3 + 4'd1;
      end
    end
  end

  assign running = (r_state == S_RUN);
  assign ovf     = r_ovf;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        r_hold;
  logic [15:0] r_disp;

  // Capture uses the pre-increment count of the cycle that sees lap
  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      r_hold <= 1'b0;
      r_disp <= 16'd0;
    end else if (lap) begin
      if (r_state == S_RUN) begin
        r_hold <= !r_hold;
        if (!r_hold) r_disp <= {r_d3, r_d2, r_d1, r_d0};
      end else begin
        r_hold <= 1'b0;
      end
    end
  end

  assign {d3, d2, d1, d0} = r_hold ? r_disp : {r_d3, r_d2, r_d1, r_d0};
  assign lap_held         = r_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap     = lap;
  assign {d3, d2, d1, d0} = {r_d3, r_d2, r_d1, r_d0};
  assign lap_held         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
// ============================================================================
// Module   : tb_stopwatch_core
// Purpose  : Directed self-checking bench for stopwatch_core (WRAP_TENS 5 and 2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       startstop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] d3, d2, d1, d0;
  logic       running, ovf, lap_held;
  logic [3:0] e3, e2, e1, e0;
  logic       running2, ovf2, lap_held2;

  int checks = 0;
  int fails  = 0;
  int ovf_cnt = 0;
  int ovf2_cnt = 0;
  int snap, snap2;

  stopwatch_core #(.WRAP_TENS(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .startstop(startstop), .clear(clear),
    .lap(lap), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .running(running),
    .ovf(ovf), .lap_held(lap_held)
  );

  stopwatch_core #(.WRAP_TENS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .startstop(startstop), .clear(clear),
    .lap(lap), .d3(e3), .d2(e2), .d1(e1), .d0(e0), .running(running2),
    .ovf(ovf2), .lap_held(lap_held2)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (ovf)  ovf_cnt++;
    if (ovf2) ovf2_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic start_run;
    do_reset();
    startstop = 1'b1;
    step();
    startstop = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      fails++; $display("FAIL reset_digits: got %h want 0000", {d3, d2, d1, d0});
    end
    checks++;
    if ({running, ovf, lap_held} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {running, ovf, lap_held});
    end
  endtask

  task automatic test_count;
    start_run();
    snap = ovf_cnt;
    checks++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL count_running: got %b want 1", running);
    end
    tick_n(250);
    step();
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0250) begin
      fails++; $display("FAIL count_250: got %h want 0250", {d3, d2, d1, d0});
    end
    checks++;
    if (ovf_cnt - snap !== 0) begin
      fails++; $display("FAIL count_no_ovf: got %0d pulses want 0", ovf_cnt - snap);
    end
  endtask

  task automatic test_wrap;
    start_run();
    snap  = ovf_cnt;
    snap2 = ovf2_cnt;
    tick_n(2999);
    checks++;
    if ({e3, e2, e1, e0} !== 16'h2999) begin
      fails++; $display("FAIL wrap2_pre: got %h want 2999", {e3, e2, e1, e0});
    end
    tick_n(1);
    checks++;
    if ({e3, e2, e1, e0, ovf2} !== {16'h0000, 1'b1}) begin
      fails++; $display("FAIL wrap2_edge: got %h ovf %b want 0000 ovf 1", {e3, e2, e1, e0}, ovf2);
    end
    checks++;
    if ({d3, d2, d1, d0, ovf} !== {16'h3000, 1'b0}) begin
      fails++; $display("FAIL wrap5_mid: got %h ovf %b want 3000 ovf 0", {d3, d2, d1, d0}, ovf);
    end
    step();
    checks++;
    if (ovf2 !== 1'b0 || ovf2_cnt - snap2 !== 1) begin
      fails++; $display("FAIL wrap2_ovf_width: got ovf %b pulses %0d want 0 and 1", ovf2, ovf2_cnt - snap2);
    end
    tick_n(2999);
    checks++;
    if ({d3, d2, d1, d0} !== 16'h5999) begin
      fails++; $display("FAIL wrap5_pre: got %h want 5999", {d3, d2, d1, d0});
    end
    tick_n(1);
    checks++;
    if ({d3, d2, d1, d0, ovf} !== {16'h0000, 1'b1}) begin
      fails++; $display("FAIL wrap5_edge: got %h ovf %b want 0000 ovf 1", {d3, d2, d1, d0}, ovf);
    end
    step();
    checks++;
    if (ovf !== 1'b0 || ovf_cnt - snap !== 1 || running !== 1'b1) begin
      fails++; $display("FAIL wrap5_after: got ovf %b pulses %0d running %b want 0 1 1", ovf, ovf_cnt - snap, running);
    end
    tick_n(3);
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0003) begin
      fails++; $display("FAIL wrap5_continue: got %h want 0003", {d3, d2, d1, d0});
    end
  endtask

  task automatic test_simultaneous;
    start_run();
    tick_n(5);
    startstop = 1'b1; tick = 1'b1;
    step();
    startstop = 1'b0; tick = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running} !== {16'h0006, 1'b0}) begin
      fails++; $display("FAIL stop_tick: got %h running %b want 0006 running 0", {d3, d2, d1, d0}, running);
    end
    tick_n(10);
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0006) begin
      fails++; $display("FAIL stop_frozen: got %h want 0006", {d3, d2, d1, d0});
    end
    startstop = 1'b1; tick = 1'b1;
    step();
    startstop = 1'b0; tick = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running} !== {16'h0006, 1'b1}) begin
      fails++; $display("FAIL resume_tick: got %h running %b want 0006 running 1", {d3, d2, d1, d0}, running);
    end
    tick_n(1);
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0007) begin
      fails++; $display("FAIL resume_count: got %h want 0007", {d3, d2, d1, d0});
    end
  endtask

  task automatic test_clear;
    start_run();
    tick_n(1234);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running} !== {16'h1234, 1'b1}) begin
      fails++; $display("FAIL clear_in_run: got %h running %b want 1234 running 1", {d3, d2, d1, d0}, running);
    end
    startstop = 1'b1;
    step();
    clear = 1'b1;
    step();
    startstop = 1'b0; clear = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running} !== {16'h0000, 1'b0}) begin
      fails++; $display("FAIL clear_wins: got %h running %b want 0000 running 0", {d3, d2, d1, d0}, running);
    end
    startstop = 1'b1;
    step();
    startstop = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running} !== {16'h0000, 1'b1}) begin
      fails++; $display("FAIL idle_to_run: got %h running %b want 0000 running 1", {d3, d2, d1, d0}, running);
    end
  endtask

  task automatic test_rst_midrun;
    start_run();
    tick_n(789);
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0789) begin
      fails++; $display("FAIL rst_pre: got %h want 0789", {d3, d2, d1, d0});
    end
    rst = 1'b1; tick = 1'b1;
    step();
    rst = 1'b0; tick = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, running, ovf} !== {16'h0000, 2'b00}) begin
      fails++; $display("FAIL rst_midrun: got %h running %b ovf %b want 0000 0 0", {d3, d2, d1, d0}, running, ovf);
    end
  endtask

  task automatic test_lap;
    start_run();
    tick_n(300);
    lap = 1'b1;
    step();
    lap = 1'b0;
    tick_n(100);
`ifdef STOPWATCH_LAP_HOLD_EN
    checks++;
    if ({d3, d2, d1, d0, lap_held} !== {16'h0300, 1'b1}) begin
      fails++; $display("FAIL lap_hold: got %h held %b want 0300 held 1", {d3, d2, d1, d0}, lap_held);
    end
`else
    checks++;
    if ({d3, d2, d1, d0, lap_held} !== {16'h0400, 1'b0}) begin
      fails++; $display("FAIL lap_ignored: got %h held %b want 0400 held 0", {d3, d2, d1, d0}, lap_held);
    end
`endif
    lap = 1'b1;
    step();
    lap = 1'b0;
    checks++;
    if ({d3, d2, d1, d0, lap_held} !== {16'h0400, 1'b0}) begin
      fails++; $display("FAIL lap_release: got %h held %b want 0400 held 0", {d3, d2, d1, d0}, lap_held);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_count();
    test_wrap();
    test_simultaneous();
    test_clear();
    test_rst_midrun();
    test_lap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
